// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter/sequencer in front of a single memory interface.
//   Port 0 is instruction fetch, port 1 is load/store. One requester is granted
//   at a time; its we/addr/wdata are latched at grant and presented to memory
//   until mem_mfc arrives (or the access times out). Completion is reported with
//   a one-cycle ack pulse, plus err on timeout. All outputs are registered.
//
// Parameters
//   TIMEOUT    cycles spent in ACCESS without mem_mfc before aborting (>= 1)
//   FIXED_PRIO 0 = round-robin on ties, 1 = port 0 always wins ties
//
// Ports
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   req[1:0], we[1:0]    per-port request level and write enable
//   addr[63:0]           packed addresses, port p = addr[32p+:32]
//   wdata[63:0]          packed write data, port p = wdata[32p+:32]
//   ack[1:0], err[1:0]   one-cycle completion / error pulses
//   rdata[31:0]          data of the last completed read, valid with ack
//   busy                 high whenever the sequencer is not idle
//   mem_read, mem_write  memory strobes (never both high)
//   mem_addr, mem_wdata  memory address / write data, held during the access
//   mem_rdata, mem_mfc   memory read data and function-complete level

module mem_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_mfc
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           last_grant_r, last_grant_s;
  logic           win_r, win_s;
  logic           pick_s;
  logic [1:0]     ack_r, ack_s;
  logic [1:0]     err_r, err_s;
  logic [31:0]    rdata_r, rdata_s;
  logic           busy_r, busy_s;
  logic           mem_read_r, mem_read_s;
  logic           mem_write_r, mem_write_s;
  logic [31:0]    mem_addr_r, mem_addr_s;
  logic [31:0]    mem_wdata_r, mem_wdata_s;

  // Arbitration: single requester wins outright; ties go by policy.
  always_comb begin
    pick_s = 1'b0;
    case (req)
      2'b01: pick_s = 1'b0;
      2'b10: pick_s = 1'b1;
      2'b11: begin
        if (FIXED_PRIO) begin
          pick_s = 1'b0;
        end else begin
          pick_s = ~last_grant_r;
        end
      end
      default: pick_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    win_s        = win_r;
    ack_s        = 2'b00;
    err_s        = 2'b00;
    rdata_s      = rdata_r;
    mem_read_s   = mem_read_r;
    mem_write_s  = mem_write_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;

    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          win_s        = pick_s;
          last_grant_s = pick_s;
          mem_read_s   = ~we[pick_s];
          mem_write_s  = we[pick_s];
          mem_addr_s   = pick_s ? addr[63:32]  : addr[31:0];
          mem_wdata_s  = pick_s ? wdata[63:32] : wdata[31:0];
          cnt_s        = {CW{1'b0}};
          state_s      = ST_ACCESS;
        end else begin
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
        end
      end

      ST_ACCESS: begin
        // mfc is checked first so it wins on the timeout cycle.
        if (mem_mfc) begin
          ack_s = win_r ? 2'b10 : 2'b01;
          if (mem_read_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          cnt_s       = {CW{1'b0}};
          state_s     = ST_RELEASE;
        end else if (cnt_r == CNT_LAST) begin
          ack_s       = win_r ? 2'b10 : 2'b01;
          err_s       = win_r ? 2'b10 : 2'b01;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          cnt_s       = {CW{1'b0}};
          state_s     = ST_RELEASE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      ST_RELEASE: begin
        // Wait for mfc to fall so the next access never sees a stale completion.
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        if (!mem_mfc) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end

      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        cnt_s       = {CW{1'b0}};
        state_s     = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset drops strobes without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      last_grant_r <= 1'b1;
      win_r        <= 1'b0;
      ack_r        <= 2'b00;
      err_r        <= 2'b00;
      rdata_r      <= 32'h0000_0000;
      busy_r       <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      win_r        <= win_s;
      ack_r        <= ack_s;
      err_r        <= err_s;
      rdata_r      <= rdata_s;
      busy_r       <= busy_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
    end
  end

  assign ack       = ack_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Instance u_rr is round-robin with
// TIMEOUT=8; instance u_fp uses fixed priority. Both share requester inputs
// and each has its own small memory model that raises mfc a programmable
// number of cycles after its strobe rises (0 = never).

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we  = 2'b00;
  logic [63:0] addr  = 64'h0;
  logic [63:0] wdata = 64'h0;
  logic [31:0] mem_rdata = 32'h0;

  logic [1:0]  ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1, ma0, ma1, mwd0, mwd1;
  logic        busy0, busy1, mr0, mw0, mr1, mw1;
  logic        mfc0, mfc1;

  int          mdelay = 0;
  logic        force_mfc = 1'b0;
  int          scnt0 = 0, scnt1 = 0;
  logic        mfc_m0 = 1'b0, mfc_m1 = 1'b0;

  int          n_checks = 0, n_pass = 0;
  int          bad_strobe = 0, bad_hold = 0, bad_err = 0, bad_ack = 0;
  logic        prev_s0 = 1'b0;
  logic [31:0] prev_a0 = 32'h0, prev_wd0 = 32'h0;

  assign mfc0 = mfc_m0 | force_mfc;
  assign mfc1 = mfc_m1 | force_mfc;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0),
    .mem_read(mr0), .mem_write(mw0), .mem_addr(ma0), .mem_wdata(mwd0),
    .mem_rdata(mem_rdata), .mem_mfc(mfc0)
  );

  mem_arbiter #(.TIMEOUT(8), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack1), .err(err1), .rdata(rdata1), .busy(busy1),
    .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1), .mem_wdata(mwd1),
    .mem_rdata(mem_rdata), .mem_mfc(mfc1)
  );

  // Memory models: mfc rises mdelay negedges after strobe rises, clears when strobe falls.
  always @(negedge clk) begin
    if (mr0 | mw0) begin
      scnt0 <= scnt0 + 1;
      if (mdelay != 0 && scnt0 + 1 >= mdelay) mfc_m0 <= 1'b1;
    end else begin
      scnt0  <= 0;
      mfc_m0 <= 1'b0;
    end
    if (mr1 | mw1) begin
      scnt1 <= scnt1 + 1;
      if (mdelay != 0 && scnt1 + 1 >= mdelay) mfc_m1 <= 1'b1;
    end else begin
      scnt1  <= 0;
      mfc_m1 <= 1'b0;
    end
  end

  // Invariant monitor: strobe exclusivity, ack/err shape, held address/data.
  always @(negedge clk) begin
    if ((mr0 & mw0) | (mr1 & mw1)) bad_strobe <= bad_strobe + 1;
    if (ack0 == 2'b11 || ack1 == 2'b11) bad_ack <= bad_ack + 1;
    if ((err0 & ~ack0) != 2'b00 || (err1 & ~ack1) != 2'b00) bad_err <= bad_err + 1;
    if ((mr0 | mw0) && prev_s0 && (ma0 != prev_a0 || mwd0 != prev_wd0)) bad_hold <= bad_hold + 1;
    prev_s0  <= mr0 | mw0;
    prev_a0  <= ma0;
    prev_wd0 <= mwd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for an ack on u_rr; counts strobe-high negedges seen on the way.
  task automatic wait_ack(input int limit, output logic [1:0] a, output logic [1:0] e,
                          output int cyc, output int sc);
    a = 2'b00; e = 2'b00; cyc = 0; sc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (mr0 | mw0) sc++;
      if (ack0 != 2'b00) begin
        a = ack0;
        e = err0;
        break;
      end
    end
  endtask

  logic [1:0] a, e;
  int         cyc, sc, k, fp0, fp1;
  logic [3:0] order;

  initial begin
    // ---- Reset state ----
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_ack_err", {28'h0, ack0, err0}, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_strobes_busy", {29'h0, busy0, mr0, mw0}, 32'h0);
    check("rst_addr_wdata", ma0 | mwd0, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- 1: read on port 0 ----
    mdelay = 3; mem_rdata = 32'h1234_5678;
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h0000_0100};
    @(negedge clk);
    check("rd_strobe", {30'h0, mr0, mw0}, 32'h2);
    check("rd_addr", ma0, 32'h0000_0100);
    wait_ack(20, a, e, cyc, sc);
    req = 2'b00;
    check("rd_ack", {30'h0, a}, 32'h1);
    check("rd_err", {30'h0, e}, 32'h0);
    check("rd_latency", cyc, 32'd3);
    check("rd_rdata", rdata0, 32'h1234_5678);
    check("rd_strobe_dropped", {31'h0, mr0}, 32'h0);
    repeat (3) @(negedge clk);

    // ---- 2: write on port 1, fields latched at grant ----
    mdelay = 2; mem_rdata = 32'hAAAA_AAAA;
    req = 2'b10; we = 2'b10; addr = {32'h0000_0200, 32'h0}; wdata = {32'hCAFE_F00D, 32'h0};
    @(negedge clk);
    check("wr_strobe", {30'h0, mr0, mw0}, 32'h1);
    check("wr_addr", ma0, 32'h0000_0200);
    check("wr_wdata", mwd0, 32'hCAFE_F00D);
    wdata = {32'hDEAD_BEEF, 32'h0};
    @(negedge clk);
    check("wr_wdata_held", mwd0, 32'hCAFE_F00D);
    wait_ack(20, a, e, cyc, sc);
    req = 2'b00; we = 2'b00;
    check("wr_ack", {30'h0, a}, 32'h2);
    check("wr_err", {30'h0, e}, 32'h0);
    check("wr_rdata_kept", rdata0, 32'h1234_5678);
    repeat (3) @(negedge clk);

    // ---- 3 & 4: both requesting, round-robin vs fixed priority ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdelay = 2; mem_rdata = 32'h0BAD_CAFE;
    req = 2'b11; we = 2'b00; addr = {32'h0000_0400, 32'h0000_0300};
    k = 0; fp0 = 0; fp1 = 0; order = 4'b0000;
    for (int i = 0; i < 80 && k < 4; i++) begin
      @(negedge clk);
      if (ack1[0]) fp0++;
      if (ack1[1]) fp1++;
      if (ack0 != 2'b00) begin
        order[k] = ack0[1];
        k++;
      end
    end
    req = 2'b00;
    check("rr_count", k, 32'd4);
    check("rr_order", {28'h0, order}, 32'h0000_000A);
    check("rr_rdata", rdata0, 32'h0BAD_CAFE);
    check("fp_port0_acks", fp0, 32'd4);
    check("fp_port1_acks", fp1, 32'd0);
    repeat (4) @(negedge clk);

    // ---- 5: timeout, then mfc held high in RELEASE ----
    mdelay = 0; mem_rdata = 32'h5555_5555;
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h0000_0500};
    @(negedge clk);
    check("tmo_strobe", {31'h0, mr0}, 32'h1);
    wait_ack(40, a, e, cyc, sc);
    req = 2'b00;
    force_mfc = 1'b1;
    check("tmo_ack", {30'h0, a}, 32'h1);
    check("tmo_err", {30'h0, e}, 32'h1);
    check("tmo_strobe_cycles", sc + 1, 32'd8);
    check("tmo_rdata_kept", rdata0, 32'h0BAD_CAFE);
    repeat (5) @(negedge clk);
    check("rel_hold_busy", {31'h0, busy0}, 32'h1);
    check("rel_hold_strobes", {28'h0, mr0, mw0, ack0}, 32'h0);
    force_mfc = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_exit_busy", {31'h0, busy0}, 32'h0);
    repeat (2) @(negedge clk);

    // ---- 6: asynchronous reset mid-access ----
    mdelay = 0;
    req = 2'b01; we = 2'b00; addr = {32'h0000_0700, 32'h0000_0600};
    @(negedge clk);
    check("ar_in_access", {30'h0, busy0, mr0}, 32'h3);
    req = 2'b11;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_strobe_busy", {29'h0, busy0, mr0, mw0}, 32'h0);
    check("ar_no_ack", {28'h0, ack0, err0}, 32'h0);
    @(negedge clk);
    rst = 1'b0; mdelay = 2;
    wait_ack(20, a, e, cyc, sc);
    req = 2'b00;
    check("ar_first_grant", {30'h0, a}, 32'h1);
    repeat (4) @(negedge clk);

    // ---- Invariants observed over the whole run ----
    check("never_both_strobes", bad_strobe, 32'd0);
    check("ack_onehot", bad_ack, 32'd0);
    check("err_with_ack", bad_err, 32'd0);
    check("addr_wdata_held", bad_hold, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
